// File: rtl/reset_request_controller_pkg.sv
// Shared types for the reset request controller: sequencer states, the registered
// output bundle and the default drain timeout.
package reset_request_controller_pkg;

    localparam int DefaultDrainTimeout = 256;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StFire,
        StWaitAssert,
        StWaitRelease,
        StDone
    } ResetCtrlState;

    typedef struct packed {
        logic drainReq;
        logic rstOut;
        logic busy;
        logic done;
    } CtrlOutputs;

    // Output values held while the sequencer sits in a given state.
    function automatic CtrlOutputs decodeOutputs(input ResetCtrlState s);
        CtrlOutputs o;
        o.drainReq = (s == StDrain);
        o.rstOut   = (s == StFire);
        o.busy     = (s != StIdle);
        o.done     = (s == StDone);
        return o;
    endfunction

endpackage

// File: rtl/drain_timer.sv
// Clearable saturating cycle counter; terminal is high once Limit cycles have been counted.
// Used by reset_request_controller only when RAFI_RESET_CTRL_TIMEOUT_EN is defined.
module drain_timer
    import reset_request_controller_pkg::*;
#(
    parameter int Limit = DefaultDrainTimeout
) (
    input  logic clk,
    input  logic rstN,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int Width = $clog2(Limit + 1);
    localparam logic [Width-1:0] LastCount = Width'(Limit);

    logic [Width-1:0] count;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LastCount)) begin
            count <= count + Width'(1);
        end
    end

    assign terminal = (count == LastCount);

endmodule

// File: rtl/reset_request_controller.sv
// Turns power-on and software reset requests into a one-cycle stretcher request, draining
// the core first on software resets. Drain timeout is built only with RAFI_RESET_CTRL_TIMEOUT_EN.
module reset_request_controller
    import reset_request_controller_pkg::*;
#(
    parameter int DrainTimeout = DefaultDrainTimeout
) (
    input  logic clk,
    input  logic rstN,
    input  logic swResetReq,
    output logic drainReq,
    input  logic drainAck,
    output logic rstOut,
    input  logic rstBusy,
    output logic busy,
    output logic done,
    output logic timedOut
);

    if (DrainTimeout < 1) begin : gBadDrainTimeout
        $error("reset_request_controller: DrainTimeout must be at least 1");
    end

    ResetCtrlState state;
    CtrlOutputs    outs;
    logic          drainExpired;

    // Reset lands in FIRE: power-on needs no drain, and rstOut is asserted for as long
    // as rstN is low plus the first clocked cycle after release.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= StFire;
            outs  <= decodeOutputs(StFire);
        end else begin
            case (state)
                StIdle: begin
                    if (swResetReq) begin
                        state <= StDrain;
                        outs  <= decodeOutputs(StDrain);
                    end
                end
                StDrain: begin
                    if (drainAck || drainExpired) begin
                        state <= StFire;
                        outs  <= decodeOutputs(StFire);
                    end
                end
                StFire: begin
                    state <= StWaitAssert;
                    outs  <= decodeOutputs(StWaitAssert);
                end
                StWaitAssert: begin
                    if (rstBusy) begin
                        state <= StWaitRelease;
                        outs  <= decodeOutputs(StWaitRelease);
                    end
                end
                StWaitRelease: begin
                    if (!rstBusy) begin
                        state <= StDone;
                        outs  <= decodeOutputs(StDone);
                    end
                end
                StDone: begin
                    state <= StIdle;
                    outs  <= decodeOutputs(StIdle);
                end
                default: begin
                    state <= StIdle;
                    outs  <= decodeOutputs(StIdle);
                end
            endcase
        end
    end

    assign drainReq = outs.drainReq;
    assign rstOut   = outs.rstOut;
    assign busy     = outs.busy;
    assign done     = outs.done;

`ifdef RAFI_RESET_CTRL_TIMEOUT_EN
    logic timedOutQ;

    // Counts only unacknowledged drain cycles; terminal count gives DrainTimeout+1 drain cycles.
    drain_timer #(
        .Limit (DrainTimeout)
    ) uDrainTimer (
        .clk      (clk),
        .rstN     (rstN),
        .clear    (state != StDrain),
        .enable   ((state == StDrain) && !drainAck),
        .terminal (drainExpired)
    );

    // Ack beats timeout in the same cycle, so a late-but-present ack never flags.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            timedOutQ <= 1'b0;
        end else if ((state == StIdle) && swResetReq) begin
            timedOutQ <= 1'b0;
        end else if ((state == StDrain) && !drainAck && drainExpired) begin
            timedOutQ <= 1'b1;
        end
    end

    assign timedOut = timedOutQ;
`else
    assign drainExpired = 1'b0;
    assign timedOut     = 1'b0;
`endif

endmodule

// File: tb/tb_reset_request_controller.sv
// Self-checking bench for reset_request_controller with randomized drain/stretcher timing;
// expectations follow RAFI_RESET_CTRL_TIMEOUT_EN the same way the design build does.
module tb_reset_request_controller;

    localparam int T = 4;
`ifdef RAFI_RESET_CTRL_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstN;
    logic swResetReq = 1'b0;
    logic drainAck = 1'b0;
    logic rstBusy = 1'b0;
    logic drainReq, rstOut, busy, done, timedOut;

    int nTests = 0;
    int nFail = 0;
    bit expTimedOut = 1'b0;

    reset_request_controller #(
        .DrainTimeout (T)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .swResetReq (swResetReq),
        .drainReq   (drainReq),
        .drainAck   (drainAck),
        .rstOut     (rstOut),
        .rstBusy    (rstBusy),
        .busy       (busy),
        .done       (done),
        .timedOut   (timedOut)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Reference model: drain lasts until the ack cycle, or DrainTimeout+1 cycles when the
    // timeout exists and the ack would arrive later than that.
    function automatic int expDrainCycles(input int ackDelay);
        if (TimeoutEn && (ackDelay > T)) return T + 1;
        return ackDelay + 1;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Called at an IDLE negedge; leaves the bench at the first DRAIN negedge.
    task automatic request(input string name);
        nTests++;
        if (busy !== 1'b0) begin
            nFail++; $display("FAIL %s idle_busy: got %b want 0", name, busy);
        end
        nTests++;
        if (timedOut !== expTimedOut) begin
            nFail++; $display("FAIL %s sticky_timedOut: got %b want %b", name, timedOut, expTimedOut);
        end
        swResetReq = 1'b1;
        tick();
        swResetReq = 1'b0;
        nTests++;
        if (drainReq !== 1'b1) begin
            nFail++; $display("FAIL %s drainReq_rise: got %b want 1", name, drainReq);
        end
        nTests++;
        if (timedOut !== 1'b0) begin
            nFail++; $display("FAIL %s timedOut_cleared: got %b want 0", name, timedOut);
        end
    endtask

    // Holds drainAck off until drainReq has been high for ackDelay cycles; ends at the FIRE negedge.
    task automatic drain_phase(input string name, input int ackDelay);
        int cycles = 0;
        bit stray = 1'b0;
        int expCycles = expDrainCycles(ackDelay);
        bit expTo = TimeoutEn && (ackDelay > T);
        while (drainReq === 1'b1 && cycles < 400) begin
            if (rstOut !== 1'b0 || busy !== 1'b1) stray = 1'b1;
            drainAck = (cycles == ackDelay);
            cycles++;
            tick();
        end
        drainAck = 1'b0;
        nTests++;
        if (cycles != expCycles) begin
            nFail++; $display("FAIL %s drain_cycles: got %0d want %0d", name, cycles, expCycles);
        end
        nTests++;
        if (stray) begin
            nFail++; $display("FAIL %s drain_outputs: got rstOut/busy glitch want 0/1", name);
        end
        nTests++;
        if (rstOut !== 1'b1) begin
            nFail++; $display("FAIL %s fire_rstOut: got %b want 1", name, rstOut);
        end
        nTests++;
        if (timedOut !== expTo) begin
            nFail++; $display("FAIL %s timedOut: got %b want %b", name, timedOut, expTo);
        end
        expTimedOut = expTo;
    endtask

    // From the FIRE negedge: stretcher answers after busyDelay cycles, stays busy busyLen cycles.
    task automatic finish_sequence(input string name, input int busyDelay, input int busyLen,
                                   input bit holdReq);
        bit stray = 1'b0;
        rstBusy = 1'b0;
        for (int i = 0; i < busyDelay; i++) begin
            tick();
            if (rstOut !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || drainReq !== 1'b0) stray = 1'b1;
        end
        rstBusy = 1'b1;
        swResetReq = holdReq;
        for (int i = 0; i < busyLen; i++) begin
            tick();
            if (rstOut !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || drainReq !== 1'b0) stray = 1'b1;
        end
        rstBusy = 1'b0;
        tick();
        nTests++;
        if ({done, busy} !== 2'b11) begin
            nFail++; $display("FAIL %s done_pulse: got done=%b busy=%b want 1 1", name, done, busy);
        end
        tick();
        nTests++;
        if ({done, busy, drainReq} !== 3'b000) begin
            nFail++; $display("FAIL %s back_to_idle: got done=%b busy=%b drainReq=%b want 0 0 0",
                              name, done, busy, drainReq);
        end
        nTests++;
        if (stray) begin
            nFail++; $display("FAIL %s wait_outputs: got unexpected rstOut/done/drainReq want quiet", name);
        end
    endtask

    task automatic test_reset();
        rstN = 1'b1;
        #2 rstN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            nTests++;
            if ({rstOut, busy, drainReq, done, timedOut} !== 5'b11000) begin
                nFail++; $display("FAIL power_on_hold%0d: got %b want 11000", i,
                                  {rstOut, busy, drainReq, done, timedOut});
            end
        end
        @(posedge clk);
        #1 rstN = 1'b1;
        tick();
        nTests++;
        if ({rstOut, busy} !== 2'b11) begin
            nFail++; $display("FAIL power_on_fire: got %b want 11", {rstOut, busy});
        end
        expTimedOut = 1'b0;
        finish_sequence("power_on", 1, 4, 1'b0);
    endtask

    task automatic test_normal();
        request("normal");
        drain_phase("normal", 3);
        finish_sequence("normal", 2, 3, 1'b0);
    endtask

    task automatic test_timeout();
        request("timeout");
        drain_phase("timeout", 120);
        finish_sequence("timeout", 1, 2, 1'b0);
        request("timeout_clear");
        drain_phase("timeout_clear", 1);
        finish_sequence("timeout_clear", 1, 1, 1'b0);
    endtask

    task automatic test_terminal_ack();
        request("terminal_ack");
        drain_phase("terminal_ack", T);
        finish_sequence("terminal_ack", 3, 2, 1'b0);
    endtask

    task automatic test_held_request();
        request("held");
        drain_phase("held", 2);
        finish_sequence("held", 1, 3, 1'b1);
        tick();
        swResetReq = 1'b0;
        nTests++;
        if ({drainReq, busy} !== 2'b11) begin
            nFail++; $display("FAIL held_restart: got drainReq/busy=%b want 11", {drainReq, busy});
        end
        drain_phase("held_second", 0);
        finish_sequence("held_second", 2, 2, 1'b0);
    endtask

    task automatic test_reset_in_drain();
        request("reset_in_drain");
        tick();
        tick();
        #2 rstN = 1'b0;
        #1;
        nTests++;
        if ({drainReq, rstOut, busy, done, timedOut} !== 5'b01100) begin
            nFail++; $display("FAIL reset_in_drain_async: got %b want 01100",
                              {drainReq, rstOut, busy, done, timedOut});
        end
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        tick();
        nTests++;
        if ({rstOut, busy, drainReq} !== 3'b110) begin
            nFail++; $display("FAIL reset_in_drain_fire: got %b want 110", {rstOut, busy, drainReq});
        end
        expTimedOut = 1'b0;
        finish_sequence("reset_in_drain", 1, 2, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            int ackDelay = $urandom_range(0, T + 3);
            int busyDelay = $urandom_range(1, 3);
            int busyLen = $urandom_range(1, 4);
            string name = $sformatf("random%0d", i);
            request(name);
            drain_phase(name, ackDelay);
            finish_sequence(name, busyDelay, busyLen, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_timeout();
        test_terminal_ack();
        test_held_request();
        test_reset_in_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
